// File: rtl/cpu_decode.sv
// Moxie decode stage: 16-bit words from fetch become decoded instructions for
// execute. Long form1 opcodes collect a 32-bit immediate from the next two words.
module cpu_decode #(
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                fetch_valid_i,
  input  logic [15:0]         fetch_word_i,
  input  logic [PC_WIDTH-1:0] fetch_pc_i,
  output logic                fetch_ready_o,
  output logic [3:0]          reg_read_index1_o,
  output logic [3:0]          reg_read_index2_o,
  output logic                read_enable_o,
  output logic                dec_valid_o,
  input  logic                dec_ready_i,
  output logic [1:0]          dec_form_o,
  output logic [7:0]          dec_opcode_o,
  output logic [3:0]          dec_reg_a_o,
  output logic [3:0]          dec_reg_b_o,
  output logic [31:0]         dec_imm_o,
  output logic                dec_long_o,
  output logic [PC_WIDTH-1:0] dec_pc_o
);

  typedef enum logic [1:0] {S_OP, S_IMM_HI, S_IMM_LO, S_OUT} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;
  logic                w_is_long;
  logic [1:0]          w_form;
  logic [7:0]          w_opcode;
  logic [3:0]          w_reg_a;
  logic [3:0]          w_reg_b;
  logic [31:0]         w_imm;

  logic                r_re;
  logic [1:0]          r_form;
  logic [7:0]          r_opcode;
  logic [3:0]          r_reg_a;
  logic [3:0]          r_reg_b;
  logic [31:0]         r_imm;
  logic                r_long;
  logic [PC_WIDTH-1:0] r_pc;

  // Ready is gated by reset so it reads 0 while rst_i is held low.
  assign fetch_ready_o = rst_i & ~flush_i & (r_state != S_OUT);
  assign w_accept      = fetch_valid_i & fetch_ready_o;

  always_comb begin
    w_is_long = 1'b0;
    if (!fetch_word_i[15]) begin
      case (fetch_word_i[15:8])
        8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
        8'h1F, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39:
          w_is_long = 1'b1;
        default: w_is_long = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_form   = '0;
    w_opcode = '0;
    w_reg_a  = '0;
    w_reg_b  = '0;
    w_imm    = '0;
    case (fetch_word_i[15:14])
      2'b10: begin
        w_form   = 2'd2;
        w_opcode = {6'b0, fetch_word_i[13:12]};
        w_reg_a  = fetch_word_i[11:8];
        w_imm    = {24'b0, fetch_word_i[7:0]};
      end
      2'b11: begin
        w_form   = 2'd3;
        w_opcode = {4'b0, fetch_word_i[13:10]};
        w_imm    = {{21{fetch_word_i[9]}}, fetch_word_i[9:0], 1'b0};
      end
      default: begin
        w_opcode = fetch_word_i[15:8];
        w_reg_a  = fetch_word_i[7:4];
        w_reg_b  = fetch_word_i[3:0];
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    if (flush_i) begin
      w_next = S_OP;
    end else begin
      case (r_state)
        S_OP:     if (w_accept) w_next = w_is_long ? S_IMM_HI : S_OUT;
        S_IMM_HI: if (w_accept) w_next = S_IMM_LO;
        S_IMM_LO: if (w_accept) w_next = S_OUT;
        S_OUT:    if (dec_ready_i) w_next = S_OP;
        default:  w_next = S_OP;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_OP;
      r_re    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_re    <= (w_next == S_OUT) && (r_state != S_OUT);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_form   <= '0;
      r_opcode <= '0;
      r_reg_a  <= '0;
      r_reg_b  <= '0;
      r_imm    <= '0;
      r_long   <= 1'b0;
      r_pc     <= '0;
    end else if (w_accept) begin
      case (r_state)
        S_OP: begin
          r_form   <= w_form;
          r_opcode <= w_opcode;
          r_reg_a  <= w_reg_a;
          r_reg_b  <= w_reg_b;
          r_imm    <= w_is_long ? '0 : w_imm;
          r_long   <= w_is_long;
          r_pc     <= fetch_pc_i;
        end
        S_IMM_HI: r_imm[31:16] <= fetch_word_i;
        S_IMM_LO: r_imm[15:0]  <= fetch_word_i;
        default: ;
      endcase
    end
  end

  assign dec_valid_o       = (r_state == S_OUT);
  assign read_enable_o     = r_re;
  assign reg_read_index1_o = r_reg_a;
  assign reg_read_index2_o = r_reg_b;
  assign dec_form_o        = r_form;
  assign dec_opcode_o      = r_opcode;
  assign dec_reg_a_o       = r_reg_a;
  assign dec_reg_b_o       = r_reg_b;
  assign dec_imm_o         = r_imm;
  assign dec_long_o        = r_long;
  assign dec_pc_o          = r_pc;

endmodule

// File: tb/tb_cpu_decode.sv
// Bench for cpu_decode: directed cases plus random traffic against an
// instruction-level model built from the moxie decode rules.
module tb_cpu_decode;
  localparam int unsigned PCW = 32;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic            fetch_valid_i;
  logic [15:0]     fetch_word_i;
  logic [PCW-1:0]  fetch_pc_i;
  logic            fetch_ready_o;
  logic [3:0]      reg_read_index1_o;
  logic [3:0]      reg_read_index2_o;
  logic            read_enable_o;
  logic            dec_valid_o;
  logic            dec_ready_i;
  logic [1:0]      dec_form_o;
  logic [7:0]      dec_opcode_o;
  logic [3:0]      dec_reg_a_o;
  logic [3:0]      dec_reg_b_o;
  logic [31:0]     dec_imm_o;
  logic            dec_long_o;
  logic [PCW-1:0]  dec_pc_o;

  always #5 clk = ~clk;

  cpu_decode #(.PC_WIDTH(PCW)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .fetch_valid_i(fetch_valid_i), .fetch_word_i(fetch_word_i),
    .fetch_pc_i(fetch_pc_i), .fetch_ready_o(fetch_ready_o),
    .reg_read_index1_o(reg_read_index1_o), .reg_read_index2_o(reg_read_index2_o),
    .read_enable_o(read_enable_o), .dec_valid_o(dec_valid_o),
    .dec_ready_i(dec_ready_i), .dec_form_o(dec_form_o),
    .dec_opcode_o(dec_opcode_o), .dec_reg_a_o(dec_reg_a_o),
    .dec_reg_b_o(dec_reg_b_o), .dec_imm_o(dec_imm_o),
    .dec_long_o(dec_long_o), .dec_pc_o(dec_pc_o)
  );

  typedef struct packed {
    logic [1:0]  form;
    logic [7:0]  op;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [31:0] imm;
    logic        lng;
    logic [31:0] pc;
  } exp_t;

  logic [7:0] long_ops [17] = '{8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D,
                                8'h1A, 8'h1B, 8'h1D, 8'h1F, 8'h20, 8'h22,
                                8'h24, 8'h36, 8'h37, 8'h38, 8'h39};

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_words [$];
  logic [31:0] m_pc;
  bit          m_out;
  bit          m_re;
  exp_t        m_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_long_op(input logic [15:0] w);
    if (w[15]) return 1'b0;
    foreach (long_ops[i]) if (long_ops[i] == w[15:8]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t decode(input logic [15:0] w, input logic [15:0] hi,
                                  input logic [15:0] lo, input logic [31:0] pc);
    exp_t e;
    int   v;
    e = '0;
    e.pc = pc;
    if (!w[15]) begin
      e.op  = w[15:8];
      e.a   = w[7:4];
      e.b   = w[3:0];
      e.lng = is_long_op(w);
      e.imm = e.lng ? {hi, lo} : 32'h0;
    end else if (!w[14]) begin
      e.form = 2'd2;
      e.op   = {6'b0, w[13:12]};
      e.a    = w[11:8];
      e.imm  = {24'b0, w[7:0]};
    end else begin
      e.form = 2'd3;
      e.op   = {4'b0, w[13:10]};
      v = int'(w[9:0]) * 2;
      if (v >= 1024) v -= 2048;
      e.imm = 32'(v);
    end
    return e;
  endfunction

  task automatic model_reset();
    m_words.delete();
    m_out = 1'b0;
    m_re  = 1'b0;
  endtask

  // One clock: compare against the model, drive inputs, advance the model.
  task automatic step(input bit v, input logic [15:0] w, input logic [31:0] pc,
                      input bit rdy, input bit fl);
    bit exp_ready;
    @(negedge clk);
    chk("dec_valid", 32'(dec_valid_o), 32'(m_out));
    chk("read_enable", 32'(read_enable_o), 32'(m_re));
    if (m_out) begin
      chk("form", 32'(dec_form_o), 32'(m_exp.form));
      chk("opcode", 32'(dec_opcode_o), 32'(m_exp.op));
      chk("reg_a", 32'(dec_reg_a_o), 32'(m_exp.a));
      chk("reg_b", 32'(dec_reg_b_o), 32'(m_exp.b));
      chk("idx1", 32'(reg_read_index1_o), 32'(m_exp.a));
      chk("idx2", 32'(reg_read_index2_o), 32'(m_exp.b));
      chk("imm", dec_imm_o, m_exp.imm);
      chk("long", 32'(dec_long_o), 32'(m_exp.lng));
      chk("pc", dec_pc_o, m_exp.pc);
    end
    fetch_valid_i = v;
    fetch_word_i  = w;
    fetch_pc_i    = pc;
    dec_ready_i   = rdy;
    flush_i       = fl;
    #1;
    exp_ready = !m_out && !fl;
    chk("fetch_ready", 32'(fetch_ready_o), 32'(exp_ready));
    m_re = 1'b0;
    if (fl) begin
      m_words.delete();
      m_out = 1'b0;
    end else if (m_out) begin
      if (rdy) m_out = 1'b0;
    end else if (v) begin
      m_words.push_back(w);
      if (m_words.size() == 1) m_pc = pc;
      if (m_words.size() == 3) begin
        m_exp = decode(m_words[0], m_words[1], m_words[2], m_pc);
        m_out = 1'b1;
        m_re  = 1'b1;
        m_words.delete();
      end else if (m_words.size() == 1 && !is_long_op(m_words[0])) begin
        m_exp = decode(m_words[0], 16'h0, 16'h0, m_pc);
        m_out = 1'b1;
        m_re  = 1'b1;
        m_words.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(dec_valid_o), 32'h0);
    chk({tag, "_re"}, 32'(read_enable_o), 32'h0);
    chk({tag, "_fready"}, 32'(fetch_ready_o), 32'h0);
    chk({tag, "_idx1"}, 32'(reg_read_index1_o), 32'h0);
    chk({tag, "_opcode"}, 32'(dec_opcode_o), 32'h0);
    chk({tag, "_reg_a"}, 32'(dec_reg_a_o), 32'h0);
    chk({tag, "_imm"}, dec_imm_o, 32'h0);
    chk({tag, "_pc"}, dec_pc_o, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    rst_i = 1'b0; flush_i = 1'b0; fetch_valid_i = 1'b0;
    fetch_word_i = '0; fetch_pc_i = '0; dec_ready_i = 1'b0;
    model_reset();
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_i = 1'b1;

    // Short form1 with immediate acceptance downstream.
    step(1, 16'h0223, 32'h1000, 0, 0);
    chk("c1_valid", 32'(dec_valid_o), 32'h1);
    chk("c1_opcode", 32'(dec_opcode_o), 32'h02);
    chk("c1_idx1", 32'(reg_read_index1_o), 32'h2);
    chk("c1_idx2", 32'(reg_read_index2_o), 32'h3);
    chk("c1_imm", dec_imm_o, 32'h0);
    chk("c1_long", 32'(dec_long_o), 32'h0);
    chk("c1_pc", dec_pc_o, 32'h1000);
    chk("c1_re", 32'(read_enable_o), 32'h1);
    step(0, 16'h0, 32'h0, 1, 0);
    chk("c1_valid_drop", 32'(dec_valid_o), 32'h0);
    chk("c1_re_drop", 32'(read_enable_o), 32'h0);

    // Long immediate.
    step(1, 16'h0120, 32'h2000, 0, 0);
    step(1, 16'hDEAD, 32'h2002, 0, 0);
    step(1, 16'hBEEF, 32'h2004, 0, 0);
    chk("c2_imm", dec_imm_o, 32'hDEADBEEF);
    chk("c2_long", 32'(dec_long_o), 32'h1);
    chk("c2_reg_a", 32'(dec_reg_a_o), 32'h2);
    chk("c2_opcode", 32'(dec_opcode_o), 32'h01);
    chk("c2_pc", dec_pc_o, 32'h2000);
    step(0, 16'h0, 32'h0, 1, 0);

    // Form3 and form2.
    step(1, 16'hC3FF, 32'h3000, 0, 0);
    chk("c3_form", 32'(dec_form_o), 32'h3);
    chk("c3_opcode", 32'(dec_opcode_o), 32'h0);
    chk("c3_imm", dec_imm_o, 32'hFFFFFFFE);
    step(0, 16'h0, 32'h0, 1, 0);
    step(1, 16'h8A7F, 32'h3002, 0, 0);
    chk("c3b_form", 32'(dec_form_o), 32'h2);
    chk("c3b_reg_a", 32'(dec_reg_a_o), 32'hA);
    chk("c3b_imm", dec_imm_o, 32'h7F);
    step(0, 16'h0, 32'h0, 1, 0);

    // Backpressure: outputs hold, single read strobe.
    step(1, 16'h0223, 32'h1000, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 16'h0456, 32'h1002, 0, 0);
      chk("c4_valid", 32'(dec_valid_o), 32'h1);
      chk("c4_re", 32'(read_enable_o), 32'h0);
      chk("c4_fready", 32'(fetch_ready_o), 32'h0);
      chk("c4_opcode", 32'(dec_opcode_o), 32'h02);
    end
    step(0, 16'h0, 32'h0, 1, 0);
    chk("c4_valid_drop", 32'(dec_valid_o), 32'h0);

    // Flush discards a partial long instruction.
    step(1, 16'h0120, 32'h4000, 0, 0);
    step(1, 16'hDEAD, 32'h4002, 0, 0);
    step(1, 16'hBEEF, 32'h4004, 0, 1);
    chk("c5_valid", 32'(dec_valid_o), 32'h0);
    step(1, 16'h0223, 32'h1000, 0, 0);
    chk("c5_opcode", 32'(dec_opcode_o), 32'h02);
    chk("c5_long", 32'(dec_long_o), 32'h0);
    chk("c5_imm", dec_imm_o, 32'h0);
    chk("c5_pc", dec_pc_o, 32'h1000);
    step(0, 16'h0, 32'h0, 1, 0);

    // Asynchronous reset in the middle of a long instruction.
    step(1, 16'h0120, 32'h5000, 0, 0);
    fetch_valid_i = 1'b0;
    rst_i = 1'b0;
    #1;
    chk_all_zero("c6");
    model_reset();
    @(posedge clk);
    @(negedge clk) rst_i = 1'b1;
    step(1, 16'h0223, 32'h1000, 0, 0);
    chk("c6_opcode", 32'(dec_opcode_o), 32'h02);
    chk("c6_idx2", 32'(reg_read_index2_o), 32'h3);
    chk("c6_long", 32'(dec_long_o), 32'h0);
    step(0, 16'h0, 32'h0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0)
        w = {long_ops[$urandom_range(0, 16)], 8'($urandom)};
      else
        w = 16'($urandom);
      step($urandom_range(0, 3) != 0, w, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0);
    end
    step(0, 16'h0, 32'h0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
